riscv_mc_ctrl: RTL and testbench

RISCV_MC_CTRL -- requirements
Module: riscv_mc_ctrl

---
 rtl/riscv_mc_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_riscv_mc_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencer
// with opcode-driven datapath controls and a retired-instruction counter.
module riscv_mc_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      inst,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             rf_we,
    output logic [2:0]       imm_op,
    output logic             alu_a_pc,
    output logic             alu_b_imm,
    output logic [1:0]       wb_sel,
    output logic             trap,
    output logic [CNT_W-1:0] instret
);

    localparam int unsigned OPC_W = 7;

    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_TARGET = 2'b01;
    localparam logic [1:0] PC_TRAP   = 2'b10;

    localparam logic [2:0] IMM_NONE = 3'b000;
    localparam logic [2:0] IMM_I    = 3'b001;
    localparam logic [2:0] IMM_U    = 3'b010;
    localparam logic [2:0] IMM_S    = 3'b011;
    localparam logic [2:0] IMM_B    = 3'b100;
    localparam logic [2:0] IMM_J    = 3'b101;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [OPC_W-1:0] opcode;
    logic             unused_inst;

    logic             is_legal;
    logic             is_branch;
    logic             is_load;
    logic             is_store;
    logic             is_jump;
    logic [2:0]       dec_imm_op;
    logic             dec_alu_a_pc;
    logic             dec_alu_b_imm;
    logic [1:0]       dec_wb_sel;

    logic             retire;
    logic [CNT_W-1:0] instret_q;

    assign opcode      = inst[OPC_W-1:0];
    assign unused_inst = ^inst[31:OPC_W];
    assign instret     = instret_q;

    // Opcode decode; illegal opcodes leave every datapath control at zero.
    always_comb begin
        is_legal      = 1'b1;
        is_branch     = 1'b0;
        is_load       = 1'b0;
        is_store      = 1'b0;
        is_jump       = 1'b0;
        dec_imm_op    = IMM_NONE;
        dec_alu_a_pc  = 1'b0;
        dec_alu_b_imm = 1'b0;
        dec_wb_sel    = WB_ALU;
        case (opcode)
            OPC_LUI: begin
                dec_imm_op    = IMM_U;
                dec_alu_b_imm = 1'b1;
            end
            OPC_AUIPC: begin
                dec_imm_op    = IMM_U;
                dec_alu_a_pc  = 1'b1;
                dec_alu_b_imm = 1'b1;
            end
            OPC_JAL: begin
                is_jump       = 1'b1;
                dec_imm_op    = IMM_J;
                dec_alu_a_pc  = 1'b1;
                dec_alu_b_imm = 1'b1;
                dec_wb_sel    = WB_PC4;
            end
            OPC_JALR: begin
                is_jump       = 1'b1;
                dec_imm_op    = IMM_I;
                dec_alu_b_imm = 1'b1;
                dec_wb_sel    = WB_PC4;
            end
            OPC_BRANCH: begin
                is_branch     = 1'b1;
                dec_imm_op    = IMM_B;
                dec_alu_a_pc  = 1'b1;
            end
            OPC_LOAD: begin
                is_load       = 1'b1;
                dec_imm_op    = IMM_I;
                dec_alu_b_imm = 1'b1;
                dec_wb_sel    = WB_LOAD;
            end
            OPC_STORE: begin
                is_store      = 1'b1;
                dec_imm_op    = IMM_S;
                dec_alu_b_imm = 1'b1;
            end
            OPC_OPIMM: begin
                dec_imm_op    = IMM_I;
                dec_alu_b_imm = 1'b1;
            end
            OPC_OP: begin
                dec_imm_op    = IMM_NONE;
            end
            default: begin
                is_legal      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  if (imem_ready) state_next = S_DECODE;
            S_DECODE: state_next = is_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (is_branch) begin
                    state_next = S_FETCH;
                end else if (is_load || is_store) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM:    if (dmem_ready) state_next = is_store ? S_FETCH : S_WB;
            S_WB:     state_next = S_FETCH;
            S_TRAP:   state_next = S_FETCH;
            default:  state_next = S_FETCH;
        endcase
    end

    // Fetch strobes are qualified by rst_n because the reset state is FETCH
    // and the fetch must stay quiet until reset has been released.
    always_comb begin
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_PLUS4;
        rf_we     = 1'b0;
        trap      = 1'b0;
        retire    = 1'b0;
        imm_op    = IMM_NONE;
        alu_a_pc  = 1'b0;
        alu_b_imm = 1'b0;
        wb_sel    = WB_ALU;
        if (state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
            imm_op    = dec_imm_op;
            alu_a_pc  = dec_alu_a_pc;
            alu_b_imm = dec_alu_b_imm;
            wb_sel    = dec_wb_sel;
        end
        case (state)
            S_FETCH: begin
                imem_req = rst_n;
                ir_we    = rst_n & imem_ready;
            end
            S_EXEC: begin
                if (is_branch) begin
                    pc_we  = 1'b1;
                    pc_sel = branch_taken ? PC_TARGET : PC_PLUS4;
                    retire = 1'b1;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ready && is_store) begin
                    pc_we  = 1'b1;
                    retire = 1'b1;
                end
            end
            S_WB: begin
                rf_we  = 1'b1;
                pc_we  = 1'b1;
                pc_sel = is_jump ? PC_TARGET : PC_PLUS4;
                retire = 1'b1;
            end
            S_TRAP: begin
                trap   = 1'b1;
                pc_we  = 1'b1;
                pc_sel = PC_TRAP;
            end
            default: ;
        endcase
    end

    // Retired-instruction counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Randomized bench for riscv_mc_ctrl: each instruction is expanded into an
// expected cycle-by-cycle control trace from the opcode class and wait counts.
module tb_riscv_mc_ctrl;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      inst;
    logic             branch_taken;
    logic             imem_ready;
    logic             dmem_ready;
    logic             imem_req;
    logic             ir_we;
    logic             dmem_req;
    logic             dmem_we;
    logic             pc_we;
    logic [1:0]       pc_sel;
    logic             rf_we;
    logic [2:0]       imm_op;
    logic             alu_a_pc;
    logic             alu_b_imm;
    logic [1:0]       wb_sel;
    logic             trap;
    logic [CNT_W-1:0] instret;

    riscv_mc_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst         (inst),
        .branch_taken (branch_taken),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .imem_req     (imem_req),
        .ir_we        (ir_we),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .rf_we        (rf_we),
        .imm_op       (imm_op),
        .alu_a_pc     (alu_a_pc),
        .alu_b_imm    (alu_b_imm),
        .wb_sel       (wb_sel),
        .trap         (trap),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    typedef enum int {C_LUI, C_AUIPC, C_JAL, C_JALR, C_BR, C_LD, C_ST, C_OPI, C_OP, C_ILL} cls_t;

    typedef struct packed {
        logic       imem_req;
        logic       ir_we;
        logic       dmem_req;
        logic       dmem_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       rf_we;
        logic [2:0] imm_op;
        logic       alu_a_pc;
        logic       alu_b_imm;
        logic [1:0] wb_sel;
        logic       trap;
    } ctl_t;

    typedef struct {
        ctl_t exp;
        logic imr;
        logic dmr;
        logic bt;
        logic load_ir;
        logic retire;
    } step_t;

    step_t            sched[$];
    int               n_tests = 0;
    int               n_fail  = 0;
    logic [CNT_W-1:0] model_cnt = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic cls_t classify(input logic [6:0] op);
        case (op)
            7'b0110111: return C_LUI;
            7'b0010111: return C_AUIPC;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b1100011: return C_BR;
            7'b0000011: return C_LD;
            7'b0100011: return C_ST;
            7'b0010011: return C_OPI;
            7'b0110011: return C_OP;
            default:    return C_ILL;
        endcase
    endfunction

    function automatic logic [6:0] opcode_of(input cls_t c);
        case (c)
            C_LUI:   return 7'b0110111;
            C_AUIPC: return 7'b0010111;
            C_JAL:   return 7'b1101111;
            C_JALR:  return 7'b1100111;
            C_BR:    return 7'b1100011;
            C_LD:    return 7'b0000011;
            C_ST:    return 7'b0100011;
            C_OPI:   return 7'b0010011;
            default: return 7'b0110011;
        endcase
    endfunction

    // Datapath controls that hold from DECODE to WB for each opcode class.
    function automatic ctl_t dec_fields(input cls_t c);
        ctl_t d = '0;
        case (c)
            C_LUI:   begin d.imm_op = 3'b010; d.alu_b_imm = 1'b1; end
            C_AUIPC: begin d.imm_op = 3'b010; d.alu_a_pc = 1'b1; d.alu_b_imm = 1'b1; end
            C_JAL:   begin d.imm_op = 3'b101; d.alu_a_pc = 1'b1; d.alu_b_imm = 1'b1; d.wb_sel = 2'b10; end
            C_JALR:  begin d.imm_op = 3'b001; d.alu_b_imm = 1'b1; d.wb_sel = 2'b10; end
            C_BR:    begin d.imm_op = 3'b100; d.alu_a_pc = 1'b1; end
            C_LD:    begin d.imm_op = 3'b001; d.alu_b_imm = 1'b1; d.wb_sel = 2'b01; end
            C_ST:    begin d.imm_op = 3'b011; d.alu_b_imm = 1'b1; end
            C_OPI:   begin d.imm_op = 3'b001; d.alu_b_imm = 1'b1; end
            default: ;
        endcase
        return d;
    endfunction

    function automatic ctl_t actual();
        ctl_t a;
        a = {imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, rf_we,
             imm_op, alu_a_pc, alu_b_imm, wb_sel, trap};
        return a;
    endfunction

    task automatic add_step(input ctl_t e, input logic imr, input logic dmr, input logic bt,
                            input logic load_ir, input logic retire);
        step_t s;
        s.exp = e; s.imr = imr; s.dmr = dmr; s.bt = bt; s.load_ir = load_ir; s.retire = retire;
        sched.push_back(s);
    endtask

    // Expected trace: fetch waits, fetch, decode, then the class-specific tail.
    task automatic build(input logic [31:0] ins, input int fw, input int mw, input logic bt);
        cls_t c = classify(ins[6:0]);
        ctl_t d = dec_fields(c);
        ctl_t e;
        sched.delete();
        for (int i = 0; i < fw; i++) begin
            e = '0; e.imem_req = 1'b1;
            add_step(e, 1'b0, rb(), rb(), 1'b0, 1'b0);
        end
        e = '0; e.imem_req = 1'b1; e.ir_we = 1'b1;
        add_step(e, 1'b1, rb(), rb(), 1'b0, 1'b0);
        add_step(d, rb(), rb(), rb(), 1'b1, 1'b0);
        if (c == C_ILL) begin
            e = '0; e.trap = 1'b1; e.pc_we = 1'b1; e.pc_sel = 2'b10;
            add_step(e, rb(), rb(), rb(), 1'b0, 1'b0);
        end else begin
            e = d;
            if (c == C_BR) begin
                e.pc_we = 1'b1; e.pc_sel = bt ? 2'b01 : 2'b00;
            end
            add_step(e, rb(), rb(), bt, 1'b0, c == C_BR);
            if (c == C_LD || c == C_ST) begin
                e = d; e.dmem_req = 1'b1; e.dmem_we = (c == C_ST);
                for (int i = 0; i < mw; i++) add_step(e, rb(), 1'b0, rb(), 1'b0, 1'b0);
                if (c == C_ST) e.pc_we = 1'b1;
                add_step(e, rb(), 1'b1, rb(), 1'b0, c == C_ST);
            end
            if (c != C_BR && c != C_ST) begin
                e = d; e.rf_we = 1'b1; e.pc_we = 1'b1;
                e.pc_sel = (c == C_JAL || c == C_JALR) ? 2'b01 : 2'b00;
                add_step(e, rb(), rb(), rb(), 1'b0, 1'b1);
            end
        end
    endtask

    // Plays the first n scheduled cycles; entered and left on a falling edge.
    task automatic run(input logic [31:0] ins, input int n);
        for (int i = 0; i < n && i < sched.size(); i++) begin
            step_t s = sched[i];
            imem_ready   = s.imr;
            dmem_ready   = s.dmr;
            branch_taken = s.bt;
            if (s.load_ir) inst = ins;
            #1;
            check($sformatf("ctl[%0d] inst=%h", i, ins), 32'(actual()), 32'(s.exp));
            check($sformatf("instret[%0d]", i), 32'(instret), 32'(model_cnt));
            if (s.retire) model_cnt = model_cnt + CNT_W'(1);
            @(negedge clk);
        end
    endtask

    task automatic do_instr(input logic [31:0] ins, input int fw, input int mw, input logic bt);
        build(ins, fw, mw, bt);
        run(ins, sched.size());
    endtask

    function automatic logic [31:0] rand_inst();
        cls_t       c;
        logic [6:0] op;
        c = cls_t'($urandom_range(0, 9));
        if (c == C_ILL) begin
            op = 7'($urandom);
            while (classify(op) != C_ILL) op = 7'($urandom);
        end else begin
            op = opcode_of(c);
        end
        return {25'($urandom), op};
    endfunction

    initial begin
        rst_n = 1'b0; inst = 32'h0; branch_taken = 1'b0;
        imem_ready = 1'b1; dmem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_ctl", 32'(actual()), 32'h0);
        check("reset_instret", 32'(instret), 32'h0);
        rst_n = 1'b1;

        do_instr(32'h00500093, 0, 0, 1'b0);
        check("addi_retired", 32'(instret), 32'h1);
        do_instr(32'h0000A103, 0, 2, 1'b0);
        do_instr(32'h00208463, 0, 0, 1'b1);
        do_instr(32'h00208463, 1, 0, 1'b0);
        do_instr(32'hFFFFFFFF, 0, 0, 1'b0);
        do_instr(32'h0020A023, 2, 1, 1'b0);
        do_instr(32'h0080006F, 0, 0, 1'b0);
        do_instr(32'h000080E7, 0, 0, 1'b0);

        // Drive the counter to its all-ones value, then one store must wrap it.
        while (model_cnt != '1) do_instr(32'h00500093, 0, 0, 1'b0);
        check("pre_wrap", 32'(instret), 32'(CNT_W'('1)));
        do_instr(32'h0020A023, 0, 0, 1'b0);
        check("wrap", 32'(instret), 32'h0);

        for (int k = 0; k < 500; k++) begin
            do_instr(rand_inst(), ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3),
                     $urandom_range(0, 3), rb());
        end

        // Reset while a load is waiting in MEM.
        build(32'h0000A103, 0, 3, 1'b0);
        run(32'h0000A103, 3);
        dmem_ready = 1'b0;
        #1;
        check("mem_before_reset", 32'(actual()), 32'(sched[3].exp));
        #1 rst_n = 1'b0;
        #1;
        check("mem_reset_ctl", 32'(actual()), 32'h0);
        check("mem_reset_instret", 32'(instret), 32'h0);
        model_cnt = '0;
        @(negedge clk);
        check("held_reset_ctl", 32'(actual()), 32'h0);
        rst_n = 1'b1;
        do_instr(32'h00500093, 0, 0, 1'b0);
        check("post_reset_retired", 32'(instret), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
